tone_decoder: RTL

TONE_DECODER -- requirements
Module: tone_decoder

---
 rtl/tone_decoder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/tone_decoder.sv
// Tone decoder: measures square-wave half-periods and maps them
// to a musical note and octave, with confirmation and silence detection.
module tone_decoder #(
    parameter int TOL     = 1,
    parameter int TIMEOUT = 262143
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tone_in,
    output logic [3:0] note,
    output logic [2:0] octave,
    output logic       note_valid,
    output logic       note_strobe,
    output logic       silence
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        NORMALIZE,
        MATCH,
        CONFIRM
    } state_t;

    localparam logic [17:0] TMO = 18'(TIMEOUT);
    localparam logic [17:0] TOLV = 18'(TOL);

    // Half-period table (D+1) for the top octave range, index = note
    function automatic logic [9:0] entry(input logic [3:0] i);
        logic [9:0] e;
        unique case (i)
            4'd0:    e = 10'd512;
            4'd1:    e = 10'd483;
            4'd2:    e = 10'd456;
            4'd3:    e = 10'd431;
            4'd4:    e = 10'd406;
            4'd5:    e = 10'd384;
            4'd6:    e = 10'd362;
            4'd7:    e = 10'd342;
            4'd8:    e = 10'd323;
            4'd9:    e = 10'd304;
            4'd10:   e = 10'd287;
            4'd11:   e = 10'd271;
            default: e = 10'd0;
        endcase
        return e;
    endfunction

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic [17:0] cnt_q, cnt_d;
    logic [17:0] h_q, h_d;
    logic        pend_q, pend_d;
    logic [17:0] work_q, work_d;
    logic [3:0]  shift_q, shift_d;
    logic [3:0]  idx_q, idx_d;
    logic        cand_vld_q, cand_vld_d;
    logic [3:0]  cand_note_q, cand_note_d;
    logic [2:0]  cand_oct_q, cand_oct_d;
    logic [3:0]  note_q, note_d;
    logic [2:0]  oct_q, oct_d;
    logic        valid_q, valid_d;
    logic        strobe_q, strobe_d;
    logic        silence_q, silence_d;

    logic        edge_w;
    logic        tmo;
    logic [17:0] norm;
    logic [17:0] ent;
    logic [17:0] diff;
    logic        in_rng;
    logic        hit;
    logic [2:0]  oct_new;

    // Edge detect, half-period counter and measurement FSM next state
    always_comb begin
        edge_w  = sync2_q ^ prev_q;
        tmo     = (cnt_q == TMO);
        norm    = work_q >> shift_q;
        ent     = {8'd0, entry(idx_q)};
        diff    = (norm >= ent) ? (norm - ent) : (ent - norm);
        in_rng  = (norm >= 18'd270) && (norm <= 18'd513);
        hit     = (diff <= TOLV);
        oct_new = 3'(4'd8 - shift_q);

        sync1_d     = tone_in;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        state_d     = state_q;
        h_d         = h_q;
        pend_d      = pend_q;
        work_d      = work_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        cand_vld_d  = cand_vld_q;
        cand_note_d = cand_note_q;
        cand_oct_d  = cand_oct_q;
        note_d      = note_q;
        oct_d       = oct_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
        silence_d   = silence_q;

        if (edge_w) begin
            cnt_d = 18'd1;
        end else if (tmo) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 18'd1;
        end

        if (edge_w && (state_q == NORMALIZE || state_q == MATCH ||
                       state_q == CONFIRM)) begin
            h_d    = cnt_q;
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (edge_w) state_d = ARMED;
            end
            ARMED: begin
                if (edge_w) begin
                    work_d  = cnt_q;
                    pend_d  = 1'b0;
                    shift_d = 4'd1;
                    state_d = NORMALIZE;
                end else if (pend_q) begin
                    work_d  = h_q;
                    pend_d  = 1'b0;
                    shift_d = 4'd1;
                    state_d = NORMALIZE;
                end
            end
            NORMALIZE: begin
                if (in_rng) begin
                    idx_d   = 4'd0;
                    state_d = MATCH;
                end else if (shift_q == 4'd8) begin
                    cand_vld_d = 1'b0;
                    state_d    = ARMED;
                end else begin
                    shift_d = shift_q + 4'd1;
                end
            end
            MATCH: begin
                if (hit) begin
                    state_d = CONFIRM;
                end else if (idx_q == 4'd11) begin
                    cand_vld_d = 1'b0;
                    state_d    = ARMED;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            CONFIRM: begin
                if (cand_vld_q && cand_note_q == idx_q &&
                    cand_oct_q == oct_new) begin
                    strobe_d  = !valid_q || note_q != idx_q ||
                                oct_q != oct_new;
                    note_d    = idx_q;
                    oct_d     = oct_new;
                    valid_d   = 1'b1;
                    silence_d = 1'b0;
                end else begin
                    cand_vld_d  = 1'b1;
                    cand_note_d = idx_q;
                    cand_oct_d  = oct_new;
                end
                state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase

        // Silence overrides any confirm in the same cycle
        if (tmo) begin
            valid_d    = 1'b0;
            silence_d  = 1'b1;
            strobe_d   = 1'b0;
            cand_vld_d = 1'b0;
            pend_d     = 1'b0;
            state_d    = edge_w ? ARMED : IDLE;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= 18'd0;
            h_q         <= 18'd0;
            pend_q      <= 1'b0;
            work_q      <= 18'd0;
            shift_q     <= 4'd1;
            idx_q       <= 4'd0;
            cand_vld_q  <= 1'b0;
            cand_note_q <= 4'd0;
            cand_oct_q  <= 3'd0;
            note_q      <= 4'd0;
            oct_q       <= 3'd0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            silence_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            h_q         <= h_d;
            pend_q      <= pend_d;
            work_q      <= work_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            cand_vld_q  <= cand_vld_d;
            cand_note_q <= cand_note_d;
            cand_oct_q  <= cand_oct_d;
            note_q      <= note_d;
            oct_q       <= oct_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
            silence_q   <= silence_d;
        end
    end

    assign note        = note_q;
    assign octave      = oct_q;
    assign note_valid  = valid_q;
    assign note_strobe = strobe_q;
    assign silence     = silence_q;

endmodule
